// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: WIDTH-bit modulo-MODULUS up/down counter with
// count enable, range-checked parallel load and free-run / one-shot modes.
// Status outputs (tc, wrap, done, load_err) allow direct cascading:
// drive the next stage's en from (tc & en) of this stage.
module mod_n_updown_counter #(
  parameter int WIDTH       = 8,
  parameter int MODULUS     = 10,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             load_err
);

  // Highest legal count; always fits in WIDTH bits since MODULUS <= 2^WIDTH.
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // MODULUS needs one extra bit when it equals 2^WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             load_err_q, load_err_d;
  logic             at_term;

  // True when the load value lies inside 0..MODULUS-1.
  function automatic logic load_in_range(input logic [WIDTH-1:0] d);
    return ({1'b0, d} < MOD_EXT);
  endfunction

  // Out-of-range loads saturate to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
    return load_in_range(d) ? d : LAST;
  endfunction

  // Non-terminal step only: the caller handles wrap-around, so +1/-1
  // never leaves 0..MODULUS-1 and never overflows WIDTH bits.
  function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] c,
                                                  input logic dir_up);
    return dir_up ? (c + ONE) : (c - ONE);
  endfunction

  // Terminal value depends on the current direction; shared by tc and step logic.
  always_comb begin
    at_term = up_dn ? (count_q == LAST) : (count_q == '0);
  end

  // Next-state logic: load beats stepping; done freezes the counter.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    done_d     = done_q;
    load_err_d = 1'b0;
    if (load) begin
      count_d    = clamp_load(load_data);
      load_err_d = ~load_in_range(load_data);
      done_d     = 1'b0;
    end else if (en && !done_q) begin
      if (at_term) begin
        wrap_d = 1'b1;
        if (one_shot) begin
          done_d = 1'b1;
        end else begin
          count_d = up_dn ? '0 : LAST;
        end
      end else begin
        count_d = step_value(count_q, up_dn);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= RST_VAL;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = at_term;
  assign wrap     = wrap_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule
